uart_tx_fifo: RTL and testbench

- Buffered UART transmitter: host pushes bytes into an internal FIFO; a serializer drains the FIFO and sends 8N1 frames (1 start bit, 8 data bits LSB-first, 1 stop bit) on o_Tx_Serial.
- Sits on the transmit side of the UART link, upstream of the line driver.
- Lets a producer, such as a receiver or a command engine, burst bytes without waiting for each frame to finish.

---
 rtl/uart_tx_fifo.sv | 166 ++++++++++++++++
 tb/tb_uart_tx_fifo.sv | 298 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_fifo.sv
// Buffered 8N1 UART transmitter: byte FIFO feeding a registered serializer.
// Define UART_TX_FIFO_PARITY_EN to insert an even-parity bit (8E1 frames).
module uart_tx_fifo #(
    parameter int CLKS_PER_BIT    = 87,
    parameter int FIFO_DEPTH_LOG2 = 4
) (
    input  logic                     i_Clock,
    input  logic                     i_Rst_L,
    input  logic                     i_Wr_DV,
    input  logic [7:0]               i_Wr_Byte,
    output logic                     o_Full,
    output logic                     o_Empty,
    output logic [FIFO_DEPTH_LOG2:0] o_Count,
    output logic                     o_Overflow,
    output logic                     o_Tx_Serial,
    output logic                     o_Tx_Active,
    output logic                     o_Tx_Done
);
    localparam int DEPTH = 2**FIFO_DEPTH_LOG2;
    localparam int CNT_W = $clog2(CLKS_PER_BIT);
    localparam logic [FIFO_DEPTH_LOG2:0] FULL_CNT = (FIFO_DEPTH_LOG2+1)'(DEPTH);
    localparam logic [CNT_W-1:0]         LAST_CLK = CNT_W'(CLKS_PER_BIT-1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
`ifdef UART_TX_FIFO_PARITY_EN
        S_PARITY,
`endif
        S_STOP
    } t_state;

    logic [7:0]                 r_Mem [DEPTH];
    logic [FIFO_DEPTH_LOG2-1:0] r_Wr_Ptr, r_Rd_Ptr;
    logic [FIFO_DEPTH_LOG2:0]   r_Count;
    logic                       r_Overflow;

    t_state                     r_State, w_State_Next;
    logic [CNT_W-1:0]           r_Clk_Cnt, w_Clk_Cnt_Next;
    logic [2:0]                 r_Bit_Idx, w_Bit_Idx_Next;
    logic [7:0]                 r_Data, w_Data_Next;
    logic                       r_Tx_Serial, w_Serial_Next;
    logic                       r_Tx_Active, r_Tx_Done;

    logic w_Full, w_Empty, w_Wr_En, w_Pop, w_Bit_End;

    assign w_Full    = (r_Count == FULL_CNT);
    assign w_Empty   = (r_Count == '0);
    // A full FIFO drops the write even when a pop frees a slot this cycle.
    assign w_Wr_En   = i_Wr_DV && !w_Full;
    assign w_Bit_End = (r_Clk_Cnt == LAST_CLK);

    always_ff @(posedge i_Clock) begin
        if (w_Wr_En)
            r_Mem[r_Wr_Ptr] <= i_Wr_Byte;
    end

    always_ff @(posedge i_Clock or negedge i_Rst_L) begin
        if (!i_Rst_L) begin
            r_Wr_Ptr   <= '0;
            r_Rd_Ptr   <= '0;
            r_Count    <= '0;
            r_Overflow <= 1'b0;
        end else begin
            if (w_Wr_En)
                r_Wr_Ptr <= r_Wr_Ptr + 1'b1;
            if (w_Pop)
                r_Rd_Ptr <= r_Rd_Ptr + 1'b1;
            r_Overflow <= i_Wr_DV && w_Full;
            case ({w_Wr_En, w_Pop})
                2'b10:   r_Count <= r_Count + 1'b1;
                2'b01:   r_Count <= r_Count - 1'b1;
                default: r_Count <= r_Count;
            endcase
        end
    end

    always_ff @(posedge i_Clock or negedge i_Rst_L) begin
        if (!i_Rst_L) begin
            r_State     <= S_IDLE;
            r_Clk_Cnt   <= '0;
            r_Bit_Idx   <= '0;
            r_Data      <= '0;
            r_Tx_Serial <= 1'b1;
            r_Tx_Active <= 1'b0;
            r_Tx_Done   <= 1'b0;
        end else begin
            r_State     <= w_State_Next;
            r_Clk_Cnt   <= w_Clk_Cnt_Next;
            r_Bit_Idx   <= w_Bit_Idx_Next;
            r_Data      <= w_Data_Next;
            r_Tx_Serial <= w_Serial_Next;
            r_Tx_Active <= (w_State_Next != S_IDLE);
            r_Tx_Done   <= (r_State == S_STOP) && (w_State_Next == S_IDLE);
        end
    end

    always_comb begin
        w_State_Next   = r_State;
        w_Clk_Cnt_Next = r_Clk_Cnt;
        w_Bit_Idx_Next = r_Bit_Idx;
        w_Data_Next    = r_Data;
        w_Pop          = 1'b0;
        w_Serial_Next  = 1'b1;
        case (r_State)
            S_IDLE: begin
                if (!w_Empty) begin
                    w_Pop          = 1'b1;
                    w_Data_Next    = r_Mem[r_Rd_Ptr];
                    w_State_Next   = S_START;
                    w_Clk_Cnt_Next = '0;
                    w_Bit_Idx_Next = '0;
                end
            end
            S_START: begin
                w_Clk_Cnt_Next = w_Bit_End ? '0 : r_Clk_Cnt + 1'b1;
                if (w_Bit_End)
                    w_State_Next = S_DATA;
            end
            S_DATA: begin
                w_Clk_Cnt_Next = w_Bit_End ? '0 : r_Clk_Cnt + 1'b1;
                if (w_Bit_End) begin
                    w_Bit_Idx_Next = r_Bit_Idx + 1'b1;
                    if (r_Bit_Idx == 3'd7)
`ifdef UART_TX_FIFO_PARITY_EN
                        w_State_Next = S_PARITY;
`else
                        w_State_Next = S_STOP;
`endif
                end
            end
`ifdef UART_TX_FIFO_PARITY_EN
            S_PARITY: begin
                w_Clk_Cnt_Next = w_Bit_End ? '0 : r_Clk_Cnt + 1'b1;
                if (w_Bit_End)
                    w_State_Next = S_STOP;
            end
`endif
            S_STOP: begin
                w_Clk_Cnt_Next = w_Bit_End ? '0 : r_Clk_Cnt + 1'b1;
                if (w_Bit_End)
                    w_State_Next = S_IDLE;
            end
            default: w_State_Next = S_IDLE;
        endcase

        // Line level is computed from the next state so the output stays registered.
        case (w_State_Next)
            S_START:  w_Serial_Next = 1'b0;
            S_DATA:   w_Serial_Next = w_Data_Next[w_Bit_Idx_Next];
`ifdef UART_TX_FIFO_PARITY_EN
            S_PARITY: w_Serial_Next = ^w_Data_Next;
`endif
            default:  w_Serial_Next = 1'b1;
        endcase
    end

    assign o_Full      = w_Full;
    assign o_Empty     = w_Empty;
    assign o_Count     = r_Count;
    assign o_Overflow  = r_Overflow;
    assign o_Tx_Serial = r_Tx_Serial;
    assign o_Tx_Active = r_Tx_Active;
    assign o_Tx_Done   = r_Tx_Done;
endmodule

// File: tb/tb_uart_tx_fifo.sv
// Directed bench for uart_tx_fifo (CLKS_PER_BIT=4, depth 4): vector table plus
// hand-written sequences for frame timing, overflow-with-pop and mid-frame reset.
module tb_uart_tx_fifo;
    localparam int CPB = 4;
`ifdef UART_TX_FIFO_PARITY_EN
    localparam int FB = 11;
`else
    localparam int FB = 10;
`endif
    localparam int PERIOD = FB*CPB + 1;

    logic       clk, rst_n, wr;
    logic [7:0] wb;
    logic       o_full, o_empty, o_ovf, tx, act, done;
    logic [2:0] o_cnt;

    uart_tx_fifo #(.CLKS_PER_BIT(CPB), .FIFO_DEPTH_LOG2(2)) dut (
        .i_Clock(clk), .i_Rst_L(rst_n), .i_Wr_DV(wr), .i_Wr_Byte(wb),
        .o_Full(o_full), .o_Empty(o_empty), .o_Count(o_cnt), .o_Overflow(o_ovf),
        .o_Tx_Serial(tx), .o_Tx_Active(act), .o_Tx_Done(done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int failures = 0;
    logic [7:0] rx_q[$];
    logic [7:0] exp_q[$];
    int         st_q[$];
    bit         mon_busy = 1'b0;

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", nm, got, exp);
        end
    endtask

    // Line decoder: samples mid-bit on the falling clock edge.
    initial begin
        int mcyc;
        int k;
        logic [7:0] mb;
        mcyc = 0;
        mb = '0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                mon_busy = 1'b0;
            end else if (!mon_busy) begin
                if (tx === 1'b0) begin
                    mon_busy = 1'b1;
                    mcyc = 0;
                    st_q.push_back(cyc);
                end
            end else begin
                mcyc++;
                if (mcyc % CPB == CPB/2) begin
                    k = mcyc / CPB;
                    if (k == 0)
                        chk("start_bit", {31'd0, tx}, 32'd0);
                    else if (k <= 8)
                        mb[k-1] = tx;
`ifdef UART_TX_FIFO_PARITY_EN
                    else if (k == 9)
                        chk("parity_bit", {31'd0, tx}, {31'd0, ^mb});
`endif
                    else if (k == FB-1) begin
                        chk("stop_bit", {31'd0, tx}, 32'd1);
                        rx_q.push_back(mb);
                        mon_busy = 1'b0;
                    end
                end
            end
        end
    end

    typedef struct {
        logic       dv;
        logic [7:0] b;
        logic [2:0] cnt;
        logic       full;
        logic       empty;
        logic       ovf;
        logic       act;
    } vec_t;
    vec_t vt[11];

    task automatic wr_cycle(input logic [7:0] b);
        wr = 1'b1;
        wb = b;
        @(posedge clk);
        #1;
        wr = 1'b0;
    endtask

    task automatic apply_vecs(input int lo, input int hi);
        for (int i = lo; i <= hi; i++) begin
            wr = vt[i].dv;
            wb = vt[i].b;
            @(posedge clk);
            #1;
            wr = 1'b0;
            chk($sformatf("vec%0d count", i), {29'd0, o_cnt}, {29'd0, vt[i].cnt});
            chk($sformatf("vec%0d full", i), {31'd0, o_full}, {31'd0, vt[i].full});
            chk($sformatf("vec%0d empty", i), {31'd0, o_empty}, {31'd0, vt[i].empty});
            chk($sformatf("vec%0d overflow", i), {31'd0, o_ovf}, {31'd0, vt[i].ovf});
            chk($sformatf("vec%0d active", i), {31'd0, act}, {31'd0, vt[i].act});
        end
    endtask

    task automatic wait_drain();
        int n;
        n = 0;
        while (!(o_empty && !act && !mon_busy) && n < 3000) begin
            @(posedge clk);
            #1;
            n++;
        end
        chk("drain_in_budget", {31'd0, n < 3000}, 32'd1);
        repeat (3) @(posedge clk);
        #1;
    endtask

    task automatic compare_rx(input string nm);
        chk({nm, " rx_count"}, rx_q.size(), exp_q.size());
        for (int i = 0; i < rx_q.size() && i < exp_q.size(); i++)
            chk($sformatf("%s rx_byte%0d", nm, i), {24'd0, rx_q[i]}, {24'd0, exp_q[i]});
        rx_q.delete();
        exp_q.delete();
        st_q.delete();
    endtask

    initial begin
        logic [10:0] fr;
        int serr, acnt, dcyc, dcnt, found, i_cnt;

        //            dv  byte   cnt full empty ovf act
        vt[0]  = '{1'b1, 8'h01, 3'd1, 1'b0, 1'b0, 1'b0, 1'b0};
        vt[1]  = '{1'b1, 8'h02, 3'd1, 1'b0, 1'b0, 1'b0, 1'b1};
        vt[2]  = '{1'b1, 8'h03, 3'd2, 1'b0, 1'b0, 1'b0, 1'b1};
        vt[3]  = '{1'b0, 8'h00, 3'd2, 1'b0, 1'b0, 1'b0, 1'b1};
        vt[4]  = '{1'b1, 8'h11, 3'd1, 1'b0, 1'b0, 1'b0, 1'b0};
        vt[5]  = '{1'b1, 8'h22, 3'd1, 1'b0, 1'b0, 1'b0, 1'b1};
        vt[6]  = '{1'b1, 8'h33, 3'd2, 1'b0, 1'b0, 1'b0, 1'b1};
        vt[7]  = '{1'b1, 8'h44, 3'd3, 1'b0, 1'b0, 1'b0, 1'b1};
        vt[8]  = '{1'b1, 8'h55, 3'd4, 1'b1, 1'b0, 1'b0, 1'b1};
        vt[9]  = '{1'b1, 8'h66, 3'd4, 1'b1, 1'b0, 1'b1, 1'b1};
        vt[10] = '{1'b0, 8'h00, 3'd4, 1'b1, 1'b0, 1'b0, 1'b1};

        rst_n = 1'b0;
        wr = 1'b0;
        wb = 8'h00;
        repeat (3) @(posedge clk);
        #1;
        chk("rst serial", {31'd0, tx}, 32'd1);
        chk("rst active", {31'd0, act}, 32'd0);
        chk("rst done", {31'd0, done}, 32'd0);
        chk("rst overflow", {31'd0, o_ovf}, 32'd0);
        chk("rst empty", {31'd0, o_empty}, 32'd1);
        chk("rst full", {31'd0, o_full}, 32'd0);
        chk("rst count", {29'd0, o_cnt}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(posedge clk);
        #1;

        // Single 0xA5 frame, cycle-accurate waveform against the hand-built frame.
`ifdef UART_TX_FIFO_PARITY_EN
        fr = 11'b1_0_10100101_0;
`else
        fr = 11'b1_1_10100101_0;
`endif
        wr_cycle(8'hA5);
        exp_q.push_back(8'hA5);
        chk("a5 count_after_write", {29'd0, o_cnt}, 32'd1);
        chk("a5 line_high_at_write", {31'd0, tx}, 32'd1);
        serr = 0; acnt = 0; dcyc = 0; dcnt = 0;
        for (int c = 1; c <= FB*CPB + 5; c++) begin
            @(posedge clk);
            #1;
            if (tx !== ((c <= FB*CPB) ? fr[(c-1)/CPB] : 1'b1))
                serr++;
            if (act === 1'b1)
                acnt++;
            if (done === 1'b1) begin
                dcnt++;
                if (dcyc == 0)
                    dcyc = c;
            end
        end
        chk("a5 waveform_errors", serr, 32'd0);
        chk("a5 active_cycles", acnt, FB*CPB);
        chk("a5 done_cycle", dcyc, FB*CPB + 1);
        chk("a5 done_pulses", dcnt, 32'd1);
        wait_drain();
        compare_rx("a5");

        // Three back-to-back bytes.
        apply_vecs(0, 3);
        exp_q.push_back(8'h01);
        exp_q.push_back(8'h02);
        exp_q.push_back(8'h03);
        wait_drain();
        chk("burst3 empty", {31'd0, o_empty}, 32'd1);
        chk("burst3 frames", st_q.size(), 32'd3);
        if (st_q.size() == 3) begin
            chk("burst3 spacing01", st_q[1] - st_q[0], PERIOD);
            chk("burst3 spacing12", st_q[2] - st_q[1], PERIOD);
        end
        compare_rx("burst3");

        // Six bytes while the first frame starts: one dropped.
        apply_vecs(4, 10);
        exp_q.push_back(8'h11);
        exp_q.push_back(8'h22);
        exp_q.push_back(8'h33);
        exp_q.push_back(8'h44);
        exp_q.push_back(8'h55);
        wait_drain();
        compare_rx("burst6");

        // Full FIFO: write coinciding with a pop is still dropped.
        wr_cycle(8'hC0);
        wr_cycle(8'hC1);
        wr_cycle(8'hC2);
        wr_cycle(8'hC3);
        wr_cycle(8'hC4);
        chk("fullpop count_full", {29'd0, o_cnt}, 32'd4);
        chk("fullpop full_flag", {31'd0, o_full}, 32'd1);
        found = 0;
        for (int n = 0; n < 200 && found == 0; n++) begin
            @(posedge clk);
            #1;
            if (done === 1'b1)
                found = 1;
        end
        chk("fullpop done_seen", found, 32'd1);
        wr = 1'b1;
        wb = 8'h99;
        #1;
        chk("fullpop full_before_write", {31'd0, o_full}, 32'd1);
        @(posedge clk);
        #1;
        wr = 1'b0;
        chk("fullpop count_after", {29'd0, o_cnt}, 32'd3);
        chk("fullpop overflow", {31'd0, o_ovf}, 32'd1);
        @(posedge clk);
        #1;
        chk("fullpop overflow_clears", {31'd0, o_ovf}, 32'd0);
        exp_q.push_back(8'hC0);
        exp_q.push_back(8'hC1);
        exp_q.push_back(8'hC2);
        exp_q.push_back(8'hC3);
        exp_q.push_back(8'hC4);
        wait_drain();
        compare_rx("fullpop");

        // Reset during data bit 3 of 0xF0 (bit 3 is low on the line).
        wr_cycle(8'hF0);
        wr_cycle(8'h55);
        repeat (17) @(posedge clk);
        #1;
        chk("midrst line_low_bit3", {31'd0, tx}, 32'd0);
        chk("midrst count_before", {29'd0, o_cnt}, 32'd1);
        rst_n = 1'b0;
        #1;
        chk("midrst serial", {31'd0, tx}, 32'd1);
        chk("midrst count", {29'd0, o_cnt}, 32'd0);
        chk("midrst active", {31'd0, act}, 32'd0);
        chk("midrst empty", {31'd0, o_empty}, 32'd1);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        i_cnt = 0;
        for (int n = 0; n < 60; n++) begin
            @(posedge clk);
            #1;
            if (tx !== 1'b1 || act !== 1'b0)
                i_cnt++;
        end
        chk("midrst quiet_line", i_cnt, 32'd0);
        compare_rx("midrst");

        wr_cycle(8'h3C);
        exp_q.push_back(8'h3C);
        wait_drain();
        compare_rx("after_rst");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
